// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory with fixed read latency LAT.
// Optional fetch starvation guard, enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
   parameter int unsigned AW         = 32,
   parameter int unsigned DW         = 32,
   parameter int unsigned LAT        = 1,
   parameter int unsigned STARVE_MAX = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic          dm_gnt,
   output logic          dm_rvalid,
   output logic [DW-1:0] dm_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);
   localparam int unsigned CW = 3;

   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          win_dm, win_dm_n;
   logic          lat_we, lat_we_n;
   logic [AW-1:0] lat_addr, lat_addr_n;
   logic [DW-1:0] lat_wdata, lat_wdata_n;
   logic          arb;
   logic          force_if;
   logic          acc_n;
   logic          rv_n;

   if (LAT < 1 || LAT > 7 || STARVE_MAX > 3) begin : g_bad_param
      $error("mem_port_arbiter: LAT must be 1..7 and STARVE_MAX at most 3");
   end

   assign arb = (state == IDLE) && (if_req || dm_req);

`ifdef ARB_STARVE_GUARD_EN
   // Counts consecutive data wins taken while fetch was waiting.
   logic [1:0] starve;

   assign force_if = if_req && (32'(starve) >= STARVE_MAX);

   always_ff @(posedge clk) begin
      if (rst) begin
         starve <= 2'd0;
      end else if (arb) begin
         if (!win_dm_n) begin
            starve <= 2'd0;
         end else if (if_req && (starve != 2'd3)) begin
            starve <= starve + 2'd1;
         end
      end
   end
`else
   assign force_if = 1'b0;
`endif

   // Next-state, arbitration and payload latch
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      win_dm_n    = win_dm;
      lat_we_n    = lat_we;
      lat_addr_n  = lat_addr;
      lat_wdata_n = lat_wdata;
      case (state)
         IDLE: begin
            if (arb) begin
               win_dm_n    = dm_req && !force_if;
               lat_we_n    = win_dm_n && dm_we;
               lat_addr_n  = win_dm_n ? dm_addr : if_addr;
               lat_wdata_n = win_dm_n ? dm_wdata : '0;
               state_n     = ACCESS;
            end
         end
         ACCESS: begin
            cnt_n   = CW'(LAT);
            state_n = WAIT;
         end
         WAIT: begin
            cnt_n = cnt - CW'(1);
            if (cnt == CW'(1)) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign acc_n = (state_n == ACCESS);
   // Response is due in the last WAIT cycle, when the counter is about to expire.
   assign rv_n  = (state_n == WAIT) && (cnt_n == CW'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         win_dm    <= 1'b0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         if_gnt    <= 1'b0;
         dm_gnt    <= 1'b0;
         if_rvalid <= 1'b0;
         dm_rvalid <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         win_dm    <= win_dm_n;
         lat_we    <= lat_we_n;
         lat_addr  <= lat_addr_n;
         lat_wdata <= lat_wdata_n;
         if_gnt    <= acc_n && !win_dm_n;
         dm_gnt    <= acc_n && win_dm_n;
         if_rvalid <= rv_n && !win_dm_n;
         dm_rvalid <= rv_n && win_dm_n;
         mem_en    <= acc_n;
         mem_we    <= acc_n && lat_we_n;
         mem_addr  <= acc_n ? lat_addr_n : '0;
         mem_wdata <= acc_n ? lat_wdata_n : '0;
         busy      <= (state_n != IDLE);
      end
   end

   // Read data passes straight from memory in the response cycle; writes return zero.
   assign if_rdata = if_rvalid ? mem_rdata : '0;
   assign dm_rdata = (dm_rvalid && !lat_we) ? mem_rdata : '0;

endmodule
